// File: rtl/conv_l0_ctrl.sv
// Layer0 3x3 convolution sequencer: walks every output pixel in raster order and issues
// zero-padded window addresses, aligned kernel/pad/accumulate controls and output writes.
module conv_l0_ctrl #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] iaddr,
  output logic          pad,
  output logic [3:0]    ksel,
  output logic          accumulate,
  output logic          cwr,
  output logic [AW-1:0] caddr
);

  localparam int SW = AW + 2;
  localparam logic signed [SW-1:0] W_S = SW'(IMG_W);
  localparam logic signed [SW-1:0] H_S = SW'(IMG_H);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_LAST, S_WRITE, S_FIN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] row_q, row_d, col_q, col_d;
  logic [3:0]    tap_q, tap_d;
  logic [AW:0]   geom_d, geom_q;
  logic [AW-1:0] pix_d;

  logic          busy_q, done_q, pad_q, acc_q, cwr_q;
  logic [3:0]    ksel_q;
  logic [AW-1:0] iaddr_q, caddr_q;

  // Returns {pad, address} for tap k of pixel (r,c); signed math keeps border taps from aliasing.
  function automatic logic [AW:0] tap_geom(input logic [AW-1:0] r, input logic [AW-1:0] c,
                                           input logic [3:0] k);
    logic signed [SW-1:0] dy, dx, sr, sc, lin;
    logic                 p;
    case (k)
      4'd0, 4'd1, 4'd2: dy = {SW{1'b1}};
      4'd3, 4'd4, 4'd5: dy = '0;
      default:          dy = SW'(1);
    endcase
    case (k)
      4'd0, 4'd3, 4'd6: dx = {SW{1'b1}};
      4'd1, 4'd4, 4'd7: dx = '0;
      default:          dx = SW'(1);
    endcase
    sr  = $signed({2'b00, r}) + dy;
    sc  = $signed({2'b00, c}) + dx;
    p   = (sr < 0) || (sr >= H_S) || (sc < 0) || (sc >= W_S);
    lin = sr * W_S + sc;
    return {p, p ? {AW{1'b0}} : lin[AW-1:0]};
  endfunction

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    tap_d   = tap_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          row_d   = '0;
          col_d   = '0;
          tap_d   = '0;
        end
      end
      S_ISSUE: begin
        if (tap_q == 4'd8) begin
          state_d = S_LAST;
          tap_d   = '0;
        end else begin
          tap_d = tap_q + 4'd1;
        end
      end
      S_LAST: state_d = S_WRITE;
      S_WRITE: begin
        tap_d = '0;
        if (row_q == AW'(IMG_H - 1) && col_q == AW'(IMG_W - 1)) begin
          state_d = S_FIN;
        end else if (col_q == AW'(IMG_W - 1)) begin
          state_d = S_ISSUE;
          col_d   = '0;
          row_d   = row_q + AW'(1);
        end else begin
          state_d = S_ISSUE;
          col_d   = col_q + AW'(1);
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        row_d   = '0;
        col_d   = '0;
        tap_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    geom_d = tap_geom(row_d, col_d, tap_d);
    geom_q = tap_geom(row_q, col_q, tap_q);
    pix_d  = row_d * AW'(IMG_W) + col_d;
  end

  // Address/write outputs follow the state being entered; datapath controls lag one issue cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      tap_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      iaddr_q <= '0;
      pad_q   <= 1'b0;
      ksel_q  <= '0;
      acc_q   <= 1'b0;
      cwr_q   <= 1'b0;
      caddr_q <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      tap_q   <= tap_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_FIN);
      iaddr_q <= (state_d == S_ISSUE) ? geom_d[AW-1:0] : '0;
      cwr_q   <= (state_d == S_WRITE);
      caddr_q <= (state_d == S_WRITE) ? pix_d : '0;
      acc_q   <= (state_q == S_ISSUE);
      ksel_q  <= (state_q == S_ISSUE) ? tap_q : 4'd0;
      pad_q   <= (state_q == S_ISSUE) && geom_q[AW];
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign iaddr      = iaddr_q;
  assign pad        = pad_q;
  assign ksel       = ksel_q;
  assign accumulate = acc_q;
  assign cwr        = cwr_q;
  assign caddr      = caddr_q;

endmodule

// File: doc/conv_l0_ctrl.md
Name: conv_l0_ctrl

Overview:
- Sequencer for the Layer0 3x3 convolution multiply/accumulate datapath.
- Walks every output pixel of an IMG_W x IMG_H image and issues input-memory addresses for the 3x3 window, with zero padding at the borders.
- Drives the datapath's kernel select, padding select and accumulate control, then raises a write strobe with the output address when each pixel's ReLU result is valid.
- Sits between the top-level start/busy handshake and the datapath plus input and output memories.

Parameters:
- IMG_W, 64, image width in pixels (>=2)
- IMG_H, 64, image height in pixels (>=2)
- AW, 12, address width; must satisfy 2^AW >= IMG_W*IMG_H

Ports:
- clk  input  1  single system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a full-image pass; sampled only in IDLE
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse after the last output write
- iaddr  output  AW  input-memory read address; memory read latency is 1 cycle
- pad  output  1  datapath forces its data input to 0 when high; aligned with accumulate
- ksel  output  4  kernel tap index 0..8; aligned with accumulate
- accumulate  output  1  datapath accumulator enable; low clears the accumulator at the clock edge
- cwr  output  1  output-memory write strobe; the datapath result is valid in this cycle
- caddr  output  AW  output-memory write address, row*IMG_W+col

Behaviour:
- Reset: all outputs are 0, state is IDLE, and the row, col and tap counters are 0. Reset mid-pass aborts the pass immediately, with no done pulse.
- All outputs are registered.
- States:
  - IDLE -> ISSUE when start=1.
  - ISSUE: tap k = 0..8, one tap per cycle. ISSUE -> LAST after k=8.
  - LAST -> WRITE.
  - WRITE -> ISSUE for the next pixel, or -> FIN after the last pixel.
  - FIN -> IDLE.
- Tap geometry: dy = k/3 - 1, dx = k%3 - 1; source position (r+dy, c+dx).
  - The tap is padded when the source row is <0 or >=IMG_H, or the source column is <0 or >=IMG_W.
  - ISSUE cycle k: iaddr = (r+dy)*IMG_W + (c+dx), or 0 when the tap is padded.
- Pipeline alignment: the cycle after ISSUE tap k has accumulate=1, ksel=k, and pad equal to tap k's pad flag.
  - These cycles are ISSUE k=1..8 followed by LAST, so accumulate is high for exactly 9 consecutive cycles.
- WRITE cycle:
  - accumulate=0, so the accumulator clears at the end of this cycle.
  - cwr=1 and caddr = r*IMG_W + c.
  - pad=0 and ksel=0.
- Outside the accumulate window, ksel=0 and pad=0. cwr is high only in WRITE.
- Per-pixel period is 11 cycles.
- Pixel order is raster: c increments, and wraps to 0 with r+1 at c=IMG_W-1.
- The pass ends after pixel (IMG_H-1, IMG_W-1).
- Full pass: first ISSUE is 1 cycle after start; the last cwr is at cycle 11*IMG_W*IMG_H after start; done is the cycle after that.
- busy: 1 from the first ISSUE through FIN; done coincides with FIN; busy falls as the controller returns to IDLE.
- start while busy is ignored. start in the same cycle as reset is ignored, because reset wins.
- Address arithmetic uses AW+2 signed intermediates so negative border coordinates never alias to valid addresses.
- After done, the controller stays in IDLE until the next start.

Test Plan:
- Reset check: hold reset 3 cycles, then release with start=0 -> all outputs stay 0 for 20 cycles, and busy=0.
- Corner pad (IMG_W=IMG_H=4): pulse start -> for pixel (0,0), pad over taps 0..8 = 1,1,1,1,0,0,1,0,0 and iaddr over ISSUE = 0,0,0,0,0,1,0,4,5.
  - First cwr is at cycle 11 with caddr=0.
- Interior pixel (1,1), same config -> iaddr sequence 0,1,2,4,5,6,8,9,10; all 9 pads are 0; ksel 0..8 with accumulate high for 9 cycles; cwr with caddr=5.
- Full pass (4x4) -> 16 cwr pulses spaced 11 cycles apart, caddr 0..15 in order, last cwr at cycle 176, done at 177.
  - Pixel (3,3) pads taps 2,5,6,7,8.
- Busy/start: pulse start again at cycle 50 -> ignored, with no change to the caddr sequence. Pulse start after done -> a new pass begins with caddr=0.
- Reset mid-op: assert reset at cycle 60 -> the next cycle has all outputs 0; no done pulse; a subsequent start restarts from pixel (0,0).
